// File: rtl/ctrl_reg_arbiter_if.sv
// Requester-side bus of the shared control register: per-requester write
// requests in, grant/ack and the live register state out.
interface ctrl_reg_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_mask;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [7:0]  control_bus;
    logic        write_strobe;
    logic [1:0]  last_grant;

    modport master (
        output req_valid, req_mask, req_data,
        input  req_ack, control_bus, write_strobe, last_grant
    );

    modport slave (
        input  req_valid, req_mask, req_data,
        output req_ack, control_bus, write_strobe, last_grant
    );
endinterface

// File: rtl/ctrl_reg_arbiter.sv
// Round-robin arbiter granting one masked read-modify-write per cycle into a
// shared 8-bit control register with per-bit DIRECT/PULSE behaviour.
module ctrl_reg_arbiter #(
    parameter int          NumReq     = 4,
    parameter int          NumOutputs = 8,
    parameter logic [7:0]  BitValue   = 8'h00,
    parameter logic [7:0]  PulseMask  = 8'h00
) (
    input logic               clock,
    input logic               reset,
    ctrl_reg_arbiter_if.slave bus
);

    localparam logic [8:0] OutLimit   = 9'd1 << NumOutputs;
    localparam logic [7:0] OutMask    = 8'(OutLimit - 9'd1);
    localparam logic [7:0] ResetValue = BitValue & OutMask;
    localparam logic [7:0] DirectBits = ~PulseMask & OutMask;
    localparam logic [7:0] PulseBits  = PulseMask & OutMask;

    logic [1:0] ptr;
    logic [1:0] ptr_next;
    logic [1:0] cand;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic [7:0] sel_mask;
    logic [7:0] sel_data;
    logic [7:0] ctrl_q;
    logic [7:0] ctrl_d;
    logic       strobe_q;
    logic [1:0] last_grant_q;

    // Search starts at the pointer and wraps within the active requesters only,
    // so requesters at index >= NumReq can never win or stall the rotation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int i = 0; i < NumReq; i++) begin
            cand = 2'((int'(ptr) + i) % NumReq);
            if (!grant_valid && bus.req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_mask = bus.req_mask[{grant_idx, 3'b000} +: 8];
    assign sel_data = bus.req_data[{grant_idx, 3'b000} +: 8];
    assign ptr_next = (grant_idx == 2'(NumReq - 1)) ? 2'd0 : grant_idx + 2'd1;

    // PULSE bits drop every cycle and are only re-set by a masked write of 1.
    always_comb begin
        if (grant_valid) begin
            ctrl_d = (((ctrl_q & ~sel_mask) | (sel_data & sel_mask)) & DirectBits)
                   | (sel_data & sel_mask & PulseBits);
        end else begin
            ctrl_d = ctrl_q & DirectBits;
        end
    end

    // Ack is combinational so the winner sees it in its grant cycle; gating with
    // reset makes an in-flight grant vanish as soon as reset rises.
    always_comb begin
        bus.req_ack = 4'b0000;
        if (grant_valid && !reset) begin
            bus.req_ack[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            ctrl_q       <= ResetValue;
            strobe_q     <= 1'b0;
            last_grant_q <= 2'd0;
            ptr          <= 2'd0;
        end else begin
            ctrl_q   <= ctrl_d;
            strobe_q <= grant_valid;
            if (grant_valid) begin
                last_grant_q <= grant_idx;
                ptr          <= ptr_next;
            end
        end
    end

    assign bus.control_bus  = ctrl_q;
    assign bus.write_strobe = strobe_q;
    assign bus.last_grant   = last_grant_q;

endmodule
